// File: rtl/aes_stream_ctrl.sv
// Streaming sequencer in front of the AES core: takes a key and plaintext blocks over
// valid/ready, drives the core's start/opcode, and buffers ciphertext in a 2-entry FWFT FIFO.
module aes_stream_ctrl #(
  parameter logic [1:0] OP_KEY    = 2'b01,
  parameter logic [1:0] OP_ENC    = 2'b10,
  parameter logic [7:0] RCON_INIT = 8'h01,
  parameter int         TIMEOUT   = 64
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [127:0] key_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [127:0] pt_i,
  input  logic         pt_valid_i,
  output logic         pt_ready_o,
  output logic [127:0] ct_o,
  output logic         ct_valid_o,
  input  logic         ct_ready_i,
  output logic [1:0]   core_opcode_o,
  output logic         core_start_o,
  output logic [127:0] core_key_o,
  output logic [7:0]   core_r_con_o,
  output logic [127:0] core_pt_o,
  input  logic         core_key_ready_i,
  input  logic         core_cipher_ready_i,
  input  logic         core_busy_i,
  input  logic [127:0] core_ct_i,
  output logic         key_loaded_o,
  output logic         err_o,
  output logic [15:0]  blk_cnt_o
);

  typedef enum logic [2:0] {
    IDLE, KEY_START, KEY_WAIT, READY, ENC_START, ENC_WAIT, ERR
  } state_t;

  state_t         state, state_nxt;
  logic [9:0]     wd;
  logic           wd_expire, key_hs, pt_hs, push, pop;
  logic [1:0]     fifo_cnt;
  logic           wr_ptr, rd_ptr;
  logic [127:0]   fifo_mem [2];
  logic [1:0]     opcode_q;

  assign wd_expire     = (wd == 10'(TIMEOUT - 1));
  assign key_hs        = key_valid_i && key_ready_o;
  assign pt_hs         = pt_valid_i && pt_ready_o;
  assign push          = (state == ENC_WAIT) && core_cipher_ready_i;
  assign pop           = ct_valid_o && ct_ready_i;
  assign ct_valid_o    = (fifo_cnt != 2'd0);
  assign ct_o          = fifo_mem[rd_ptr];
  assign err_o         = (state == ERR);
  assign core_r_con_o  = RCON_INIT;
  assign core_opcode_o = opcode_q;

  always_comb begin
    state_nxt    = state;
    key_ready_o  = 1'b0;
    pt_ready_o   = 1'b0;
    core_start_o = 1'b0;
    case (state)
      IDLE: begin
        key_ready_o = 1'b1;
        if (key_valid_i) state_nxt = KEY_START;
      end
      KEY_START, ENC_START: begin
        // start is withheld while the core is still busy; the hold is watchdog-bounded
        core_start_o = !core_busy_i;
        if (!core_busy_i)   state_nxt = (state == KEY_START) ? KEY_WAIT : ENC_WAIT;
        else if (wd_expire) state_nxt = ERR;
      end
      KEY_WAIT: begin
        if (core_key_ready_i) state_nxt = READY;
        else if (wd_expire)   state_nxt = ERR;
      end
      READY: begin
        key_ready_o = 1'b1;
        // a pending key blocks plaintext so only one transfer happens per cycle
        pt_ready_o  = (fifo_cnt < 2'd2) && !key_valid_i;
        if (key_valid_i)     state_nxt = KEY_START;
        else if (pt_hs)      state_nxt = ENC_START;
      end
      ENC_WAIT: begin
        if (core_cipher_ready_i) state_nxt = READY;
        else if (wd_expire)      state_nxt = ERR;
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // watchdog clears on every state change and counts while parked in a start/wait state
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state <= IDLE;
      wd    <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wd <= '0;
      else if (state inside {KEY_START, KEY_WAIT, ENC_START, ENC_WAIT})
        wd <= wd + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      opcode_q     <= '0;
      core_key_o   <= '0;
      core_pt_o    <= '0;
      key_loaded_o <= 1'b0;
      blk_cnt_o    <= '0;
    end else begin
      if (key_hs) begin
        opcode_q     <= OP_KEY;
        core_key_o   <= key_i;
        key_loaded_o <= 1'b0;
      end else if (pt_hs) begin
        opcode_q  <= OP_ENC;
        core_pt_o <= pt_i;
      end
      if (state == KEY_WAIT && core_key_ready_i) key_loaded_o <= 1'b1;
      if (push) blk_cnt_o <= blk_cnt_o + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= core_ct_i;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: behavioural AES-core stub, transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_aes_stream_ctrl;
  localparam int TO      = 16;
  localparam int KEY_LAT = 12;
  localparam int ENC_LAT = 5;
  localparam logic [1:0]   OPK  = 2'b01;
  localparam logic [1:0]   OPE  = 2'b10;
  localparam logic [127:0] KEY0 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] KEY1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] PT0  = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] CT0  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] MASK = {4{32'h5a5aa5a5}};

  logic clk = 1'b0, nrst = 1'b1;
  logic [127:0] key_i = '0, pt_i = '0, ct_o, core_key_o, core_pt_o, core_ct_i = '0;
  logic key_valid_i = 1'b0, key_ready_o, pt_valid_i = 1'b0, pt_ready_o;
  logic ct_valid_o, ct_ready_i = 1'b0;
  logic [1:0] core_opcode_o;
  logic core_start_o, core_busy_i;
  logic [7:0] core_r_con_o;
  logic core_key_ready_i = 1'b0, core_cipher_ready_i = 1'b0;
  logic key_loaded_o, err_o;
  logic [15:0] blk_cnt_o;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  aes_stream_ctrl #(.OP_KEY(OPK), .OP_ENC(OPE), .RCON_INIT(8'h01), .TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst),
    .key_i(key_i), .key_valid_i(key_valid_i), .key_ready_o(key_ready_o),
    .pt_i(pt_i), .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o),
    .ct_o(ct_o), .ct_valid_o(ct_valid_o), .ct_ready_i(ct_ready_i),
    .core_opcode_o(core_opcode_o), .core_start_o(core_start_o), .core_key_o(core_key_o),
    .core_r_con_o(core_r_con_o), .core_pt_o(core_pt_o),
    .core_key_ready_i(core_key_ready_i), .core_cipher_ready_i(core_cipher_ready_i),
    .core_busy_i(core_busy_i), .core_ct_i(core_ct_i),
    .key_loaded_o(key_loaded_o), .err_o(err_o), .blk_cnt_o(blk_cnt_o)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [127:0] cipher_of(input logic [127:0] p);
    return (p == PT0) ? CT0 : (p ^ MASK);
  endfunction

  // ---------------- AES core stub: ready pulses LAT cycles after the start cycle
  logic hang = 1'b0, force_busy = 1'b0, c_busy = 1'b0, c_enc = 1'b0;
  logic c_st, c_rs;
  logic [1:0] c_op;
  logic [127:0] c_pv, c_res = '0;
  int c_cnt = 0;
  assign core_busy_i = c_busy | force_busy;

  always begin
    @(negedge clk);
    c_st = core_start_o; c_op = core_opcode_o; c_pv = core_pt_o; c_rs = nrst;
    @(posedge clk); #1;
    core_key_ready_i = 1'b0;
    core_cipher_ready_i = 1'b0;
    if (c_rs) begin
      c_busy = 1'b0; c_cnt = 0;
    end else if (c_st) begin
      c_busy = 1'b1;
      c_enc  = (c_op == OPE);
      c_cnt  = (c_enc ? ENC_LAT : KEY_LAT) - 1;
      c_res  = cipher_of(c_pv);
    end else if (c_busy) begin
      c_cnt--;
      if (c_cnt == 0) begin
        c_busy = 1'b0;
        if (!hang) begin
          if (c_enc) begin core_cipher_ready_i = 1'b1; core_ct_i = c_res; end
          else core_key_ready_i = 1'b1;
        end
      end
    end
  end

  // ---------------- transaction-level reference model + per-cycle compare
  logic m_kl = 0, m_err = 0, m_inflight = 0, m_enc = 0, m_pending = 0, m_waiting = 0;
  int m_wcnt = 0;
  logic [15:0] m_blk = '0;
  logic [127:0] m_key = '0, m_pt = '0;
  logic [1:0] m_op = '0;
  logic [127:0] m_q[$];
  int n_start = 0;
  logic [1:0] last_start_op = '0;

  always @(negedge clk) begin : compare
    logic e_kr, e_pr, e_st, do_pop;
    if (nrst) begin
      m_kl = 0; m_err = 0; m_inflight = 0; m_enc = 0; m_pending = 0; m_waiting = 0;
      m_wcnt = 0; m_blk = '0; m_key = '0; m_pt = '0; m_op = '0; m_q.delete();
      chk("ct_o_reset", ct_o, 128'h0);
    end
    e_kr = !m_err && !m_inflight;
    e_pr = e_kr && m_kl && (m_q.size() < 2) && !key_valid_i;
    e_st = m_pending && !core_busy_i;
    chk("key_ready", 128'(key_ready_o), 128'(e_kr));
    chk("pt_ready", 128'(pt_ready_o), 128'(e_pr));
    chk("ct_valid", 128'(ct_valid_o), 128'(m_q.size() > 0));
    if (m_q.size() > 0) chk("ct_o", ct_o, m_q[0]);
    chk("core_start", 128'(core_start_o), 128'(e_st));
    chk("core_opcode", 128'(core_opcode_o), 128'(m_op));
    chk("core_key", core_key_o, m_key);
    chk("core_pt", core_pt_o, m_pt);
    chk("core_r_con", 128'(core_r_con_o), 128'(8'h01));
    chk("key_loaded", 128'(key_loaded_o), 128'(m_kl));
    chk("err", 128'(err_o), 128'(m_err));
    chk("blk_cnt", 128'(blk_cnt_o), 128'(m_blk));
    if (core_start_o) begin n_start++; last_start_op = core_opcode_o; end
    if (!nrst) begin
      do_pop = (m_q.size() > 0) && ct_ready_i;
      if (do_pop) void'(m_q.pop_front());
      if (m_pending) begin
        if (!core_busy_i) begin m_pending = 0; m_waiting = 1; m_wcnt = 0; end
        else begin
          m_wcnt++;
          if (m_wcnt == TO) begin m_err = 1; m_pending = 0; end
        end
      end else if (m_waiting) begin
        if (!m_enc && core_key_ready_i) begin
          m_kl = 1; m_waiting = 0; m_inflight = 0;
        end else if (m_enc && core_cipher_ready_i) begin
          m_q.push_back(core_ct_i); m_blk = m_blk + 16'd1; m_waiting = 0; m_inflight = 0;
        end else begin
          m_wcnt++;
          if (m_wcnt == TO) begin m_err = 1; m_waiting = 0; end
        end
      end
      if (key_valid_i && e_kr) begin
        m_key = key_i; m_kl = 0; m_inflight = 1; m_enc = 0; m_pending = 1; m_wcnt = 0; m_op = OPK;
      end else if (pt_valid_i && e_pr) begin
        m_pt = pt_i; m_inflight = 1; m_enc = 1; m_pending = 1; m_wcnt = 0; m_op = OPE;
      end
    end
  end

  // ---------------- stimulus helpers
  function automatic logic cond(input int sel, input int arg);
    case (sel)
      0: return key_loaded_o;
      1: return ct_valid_o;
      2: return core_busy_i;
      3: return err_o;
      4: return (int'(blk_cnt_o) == arg);
      default: return key_ready_o;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int sel, input int arg);
    int n = 0;
    do begin @(negedge clk); n++; end while (!cond(sel, arg) && n < 300);
    chk(nm, 128'(cond(sel, arg)), 128'(1'b1));
  endtask

  task automatic offer_key(input logic [127:0] k);
    int n = 0;
    @(posedge clk); #1; key_i = k; key_valid_i = 1'b1;
    do begin @(negedge clk); n++; end while (!key_ready_o && n < 300);
    chk("key_accept", 128'(key_ready_o), 128'(1'b1));
    @(posedge clk); #1; key_valid_i = 1'b0;
  endtask

  task automatic offer_pt(input logic [127:0] p);
    int n = 0;
    @(posedge clk); #1; pt_i = p; pt_valid_i = 1'b1;
    do begin @(negedge clk); n++; end while (!pt_ready_o && n < 300);
    chk("pt_accept", 128'(pt_ready_o), 128'(1'b1));
    @(posedge clk); #1; pt_valid_i = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; nrst = 1'b1;
    #1;
    chk("rst_ct_valid", 128'(ct_valid_o), 128'(1'b0));
    chk("rst_blk_cnt", 128'(blk_cnt_o), 128'(16'h0));
    chk("rst_key_loaded", 128'(key_loaded_o), 128'(1'b0));
    chk("rst_err", 128'(err_o), 128'(1'b0));
    chk("rst_core_pt", core_pt_o, 128'h0);
    chk("rst_opcode", 128'(core_opcode_o), 128'(2'b00));
    chk("rst_pt_ready", 128'(pt_ready_o), 128'(1'b0));
    @(posedge clk); #1; nrst = 1'b0;
  endtask

  // ---------------- directed scenarios
  initial begin
    int ns0;
    int nb;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_key_ready", 128'(key_ready_o), 128'(1'b1));
    chk("reset_core_key", core_key_o, 128'h0);
    chk("reset_start", 128'(core_start_o), 128'(1'b0));
    nrst = 1'b0;

    // key load: one start pulse with the key opcode
    ct_ready_i = 1'b1;
    ns0 = n_start;
    offer_key(KEY0);
    wait_for("wait_key_loaded", 0, 0);
    chk("key_start_pulses", 128'(n_start - ns0), 128'(1));
    chk("key_start_opcode", 128'(last_start_op), 128'(2'b01));
    chk("key_value", core_key_o, KEY0);

    // single block with the FIPS-197 vector
    ct_ready_i = 1'b0;
    offer_pt(PT0);
    wait_for("wait_ct0", 1, 0);
    chk("ct0_value", ct_o, CT0);
    chk("ct0_blk_cnt", 128'(blk_cnt_o), 128'(16'd1));
    @(posedge clk); #1; ct_ready_i = 1'b1;
    @(posedge clk); #1; ct_ready_i = 1'b0;

    // backpressure: two blocks fill the FIFO, third waits
    offer_pt(128'hA);
    offer_pt(128'hB);
    wait_for("wait_fifo_full", 4, 3);
    chk("full_pt_ready", 128'(pt_ready_o), 128'(1'b0));
    chk("full_head", ct_o, 128'hA ^ MASK);
    @(posedge clk); #1; pt_i = 128'hC; pt_valid_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("full_hold_pt_ready", 128'(pt_ready_o), 128'(1'b0));
    chk("full_hold_blk", 128'(blk_cnt_o), 128'(16'd3));
    @(posedge clk); #1; ct_ready_i = 1'b1;
    wait_for("third_accept", 5, 0);
    @(negedge clk);
    @(posedge clk); #1; pt_valid_i = 1'b0;
    wait_for("third_done", 4, 4);
    repeat (3) @(posedge clk);
    #1;

    // key and plaintext together in READY: key wins
    key_i = KEY1; key_valid_i = 1'b1; pt_i = 128'hD0; pt_valid_i = 1'b1;
    @(negedge clk);
    chk("sim_pt_ready", 128'(pt_ready_o), 128'(1'b0));
    chk("sim_key_ready", 128'(key_ready_o), 128'(1'b1));
    @(posedge clk); #1; key_valid_i = 1'b0; pt_valid_i = 1'b0;
    @(negedge clk);
    chk("sim_key_loaded_clr", 128'(key_loaded_o), 128'(1'b0));
    chk("sim_opcode", 128'(core_opcode_o), 128'(2'b01));
    chk("sim_key_value", core_key_o, KEY1);
    wait_for("sim_key_loaded", 0, 0);

    // push and pop in the same cycle at occupancy 1
    ct_ready_i = 1'b0;
    offer_pt(128'hD1);
    wait_for("pp_first", 4, 5);
    offer_pt(128'hE1);
    nb = 0;
    do begin @(posedge clk); #2; nb++; end while (!core_cipher_ready_i && nb < 300);
    chk("pp_cipher_seen", 128'(core_cipher_ready_i), 128'(1'b1));
    ct_ready_i = 1'b1;
    @(posedge clk); #1; ct_ready_i = 1'b0;
    @(negedge clk);
    chk("pp_valid", 128'(ct_valid_o), 128'(1'b1));
    chk("pp_head", ct_o, 128'hE1 ^ MASK);
    chk("pp_blk", 128'(blk_cnt_o), 128'(16'd6));
    @(posedge clk); #1; ct_ready_i = 1'b1;
    @(posedge clk); #1; ct_ready_i = 1'b0;

    // busy on entry to the start state holds the pulse back
    force_busy = 1'b1;
    ns0 = n_start;
    offer_pt(128'hF0);
    repeat (3) @(negedge clk);
    chk("busy_no_start", 128'(n_start - ns0), 128'(0));
    @(posedge clk); #1; force_busy = 1'b0;
    wait_for("busy_done", 4, 7);
    chk("busy_one_start", 128'(n_start - ns0), 128'(1));

    // reset during ENC_WAIT with one FIFO entry, then a fresh key load
    wait_for("mid_ready", 5, 0);
    offer_pt(128'h1234);
    wait_for("mid_busy", 2, 0);
    @(negedge clk);
    pulse_reset();
    offer_key(KEY0);
    wait_for("mid_key_reload", 0, 0);
    chk("mid_blk_zero", 128'(blk_cnt_o), 128'(16'd0));

    // watchdog: one entry buffered, then the core never answers
    offer_pt(128'h55);
    wait_for("wd_first", 4, 1);
    hang = 1'b1;
    offer_pt(128'h66);
    wait_for("wd_err", 3, 0);
    chk("wd_key_ready", 128'(key_ready_o), 128'(1'b0));
    chk("wd_pt_ready", 128'(pt_ready_o), 128'(1'b0));
    chk("wd_blk", 128'(blk_cnt_o), 128'(16'd1));
    @(posedge clk); #1; ct_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("wd_drained", 128'(ct_valid_o), 128'(1'b0));
    chk("wd_sticky", 128'(err_o), 128'(1'b1));
    hang = 1'b0;
    pulse_reset();
    @(negedge clk);
    chk("wd_recovered", 128'(key_ready_o), 128'(1'b1));

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
